// File: rtl/rr_arb_4to1_64bit_pkg.sv
// Shared arbitration types and the round-robin search helper used by the
// 4-channel arbiters in this codebase.
package rr_arb_4to1_64bit_pkg;

  localparam int ARB_N     = 4;
  localparam int SEL_WIDTH = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Returns {any, idx}: first requester found searching ptr+1, ptr+2, ptr+3, ptr.
  function automatic logic [SEL_WIDTH:0] rr_search(
    input logic [ARB_N-1:0]     req,
    input logic [SEL_WIDTH-1:0] ptr
  );
    logic [SEL_WIDTH-1:0] idx;
    logic [SEL_WIDTH-1:0] cand;
    logic                 found;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= ARB_N; k++) begin
      cand = ptr + k[SEL_WIDTH-1:0];
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/rr_arb_4to1_64bit_pick.sv
// Combinational round-robin picker: lowest-priority slot is the last winner (ptr).
module rr_pick4
  import rr_arb_4to1_64bit_pkg::*;
(
  input  logic [ARB_N-1:0]     req,
  input  logic [SEL_WIDTH-1:0] ptr,
  output logic [SEL_WIDTH-1:0] gnt_idx,
  output logic                 any
);

  assign {any, gnt_idx} = rr_search(req, ptr);

endmodule

// File: rtl/rr_arb_4to1_64bit.sv
// Round-robin burst arbiter for four valid/ready sources feeding a registered
// valid/ready output; the grant stays on one source until its last beat.
module rr_arb_4to1_64bit
  import rr_arb_4to1_64bit_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ARB_N-1:0]     in_valid,
  input  logic [ARB_N-1:0]     in_last,
  input  logic [WIDTH-1:0]     in_data0,
  input  logic [WIDTH-1:0]     in_data1,
  input  logic [WIDTH-1:0]     in_data2,
  input  logic [WIDTH-1:0]     in_data3,
  output logic [ARB_N-1:0]     in_ready,
  output logic [SEL_WIDTH-1:0] sel,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_WIDTH-1:0] out_src,
  output logic                 out_last,
  input  logic                 out_ready
);

  state_t               state;
  logic [SEL_WIDTH-1:0] ptr;
  logic [SEL_WIDTH-1:0] lock;
  logic [SEL_WIDTH-1:0] sel_q;
  logic [SEL_WIDTH-1:0] pick_idx;
  logic                 pick_any;
  logic                 load_en;
  logic                 grant_valid;
  logic                 fire;
  logic [SEL_WIDTH-1:0] grant_idx;
  logic [WIDTH-1:0]     mux_data;

  rr_pick4 u_pick (
    .req     (in_valid),
    .ptr     (ptr),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  always_comb begin
    load_en = !out_valid || out_ready;
    if (state == LOCKED) begin
      grant_idx   = lock;
      grant_valid = in_valid[lock];
    end else begin
      grant_idx   = pick_idx;
      grant_valid = pick_any;
    end
    fire = load_en && grant_valid && !rst;
  end

  // With no requester in IDLE the select keeps pointing at the last grant.
  always_comb begin
    in_ready = '0;
    sel      = sel_q;
    if (rst) begin
      in_ready = '0;
      sel      = '0;
    end else if (state == LOCKED) begin
      sel            = lock;
      in_ready[lock] = load_en;
    end else if (pick_any) begin
      sel                = pick_idx;
      in_ready[pick_idx] = load_en;
    end else begin
      in_ready = '0;
      sel      = sel_q;
    end
  end

  always_comb begin
    case (grant_idx)
      2'd0:    mux_data = in_data0;
      2'd1:    mux_data = in_data1;
      2'd2:    mux_data = in_data2;
      2'd3:    mux_data = in_data3;
      default: mux_data = in_data0;
    endcase
  end

  // Pointer moves only when a burst completes; bubbles and stalls leave it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 2'd3;
      lock  <= 2'd0;
      sel_q <= 2'd0;
    end else begin
      sel_q <= sel;
      case (state)
        IDLE: begin
          if (fire) begin
            if (in_last[grant_idx]) begin
              ptr <= grant_idx;
            end else begin
              lock  <= grant_idx;
              state <= LOCKED;
            end
          end
        end
        LOCKED: begin
          if (fire && in_last[lock]) begin
            ptr   <= lock;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 2'd0;
      out_last  <= 1'b0;
    end else if (fire) begin
      out_valid <= 1'b1;
      out_data  <= mux_data;
      out_src   <= grant_idx;
      out_last  <= in_last[grant_idx];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
